imem_loader: RTL

Program loader for the instruction memory: accepts a byte stream over a valid/ready handshake, packs every four bytes into a 32-bit big-endian instruction word, and issues one write per word into the instruction memory's write port. Writes use byte addresses (word index × 4), the same addressing the fetch side divides by 4. It sits between the host/UART byte source and the instruction memory, and runs before the CPU is released from reset.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader_byte_packer.sv | 43 ++++
 rtl/imem_loader.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The optional checksum tail is enabled by IMEM_LOADER_CHECKSUM_EN.
package imem_pkg;

  localparam int WORD_BYTES       = 4;
  localparam int IMEM_DEPTH_WORDS = 1024;
  localparam int ADDR_SHIFT       = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CHECK,
    ST_FIN
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction-memory write port out.
// master = byte source / memory side, slave = loader.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs four accepted bytes big-endian into one 32-bit word.
// Shared by the data words and the checksum tail.
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [1:0]  cnt_q, cnt_d;
  // Only the three leading bytes need storage; the fourth arrives with word_full.
  logic [23:0] shift_q, shift_d;

  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    word_next = {shift_q, byte_in};
    word_full = accept && (cnt_q == 2'(WORD_BYTES - 1));
    if (clear) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (accept) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], byte_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads word_count big-endian words from a byte stream into instruction memory.
// Optional checksum tail compiled in with IMEM_LOADER_CHECKSUM_EN.
//
// state    | meaning
// IDLE     | waiting for start; request validated here
// RECV     | accepting the four bytes of the current word
// WRITE    | mem_we high for one cycle, index advances
// CHECK    | accepting the four checksum bytes (checksum build only)
// FIN      | done/error published, back to IDLE next cycle
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  imem_loader_if.slave     bus,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d, cnt_q, cnt_d, idx_inc;
  logic             mem_we_q, mem_we_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic             byte_ready, accept, pk_clear, pk_full;
  logic [31:0]      pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      sum_q, sum_d;
`endif

  imem_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .accept    (accept),
    .byte_in   (bus.byte_data),
    .word_next (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    pk_clear    = 1'b0;
    idx_inc     = idx_q + CNT_W'(1);
    byte_ready  = (state_q == ST_RECV);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    if (state_q == ST_CHECK) byte_ready = 1'b1;
`endif
    accept = bus.byte_valid && byte_ready;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            done_d  = 1'b1;
            error_d = 1'b0;
            state_d = ST_FIN;
          end else if (word_count > DEPTH_C) begin
            done_d  = 1'b1;
            error_d = 1'b1;
            state_d = ST_FIN;
          end else begin
            done_d   = 1'b0;
            error_d  = 1'b0;
            busy_d   = 1'b1;
            idx_d    = '0;
            cnt_d    = word_count;
            pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d    = '0;
`endif
            state_d  = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (pk_full) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = 32'(idx_q) << ADDR_SHIFT;
          mem_wdata_d = pk_word;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d = idx_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d = sum_q + mem_wdata_q;
`endif
        if (idx_inc == cnt_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FIN;
`endif
        end else begin
          state_d = ST_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (pk_full) begin
          error_d = (pk_word != sum_q);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule
